// File: rtl/linebuf_seq_ctrl.sv
// Line-buffer mode sequencer for one memory_core: primes the core with cfg_depth words,
// streams with matched read/write, drains at frame end and pulses flush.
module linebuf_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_depth,
  input  logic [CNT_W-1:0] cfg_img_width,
  input  logic [CNT_W-1:0] cfg_img_height,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mem_valid_out,
  output logic             wen,
  output logic             ren,
  output logic             flush,
  output logic             out_valid,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] occupancy,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] height_q, height_d;
  logic             flush_q, flush_d;
  logic             cfg_err_q, cfg_err_d;

  logic             in_ready_c;
  logic             accept;
  logic             wen_c;
  logic             ren_c;
  logic             last_pix;
  logic             cfg_ok;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    occ_d      = occ_q;
    depth_d    = depth_q;
    width_d    = width_q;
    height_d   = height_q;
    flush_d    = 1'b0;
    cfg_err_d  = 1'b0;

    in_ready_c = (state_q == S_FILL) || (state_q == S_STREAM);
    accept     = in_valid && in_ready_c;
    last_pix   = (col_q == width_q - ONE) && (row_q == height_q - ONE);
    cfg_ok     = (cfg_depth != '0) && (cfg_img_width != '0) && (cfg_img_height != '0);

    wen_c = accept;
    ren_c = ((state_q == S_STREAM) && accept) || ((state_q == S_DRAIN) && (occ_q != '0));

    if (wen_c && !ren_c) begin
      occ_d = occ_q + ONE;
    end else if (ren_c && !wen_c) begin
      occ_d = occ_q - ONE;
    end

    if (accept) begin
      if (col_q == width_q - ONE) begin
        col_d = '0;
        row_d = row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            depth_d  = cfg_depth;
            width_d  = cfg_img_width;
            height_d = cfg_img_height;
            col_d    = '0;
            row_d    = '0;
            occ_d    = '0;
            state_d  = S_FILL;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      // Last pixel wins over the depth match: a frame smaller than the delay drains directly.
      S_FILL: begin
        if (accept) begin
          if (last_pix) begin
            state_d = S_DRAIN;
          end else if (occ_q == depth_q - ONE) begin
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (accept && last_pix) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((ren_c && (occ_q == ONE)) || (occ_q == '0)) begin
          state_d = S_DONE;
          flush_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      occ_q     <= '0;
      flush_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      occ_q     <= occ_d;
      flush_q   <= flush_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Latched frame geometry is only consulted outside IDLE, so it needs no reset.
  always_ff @(posedge clk) begin
    depth_q  <= depth_d;
    width_q  <= width_d;
    height_q <= height_d;
  end

  assign in_ready   = in_ready_c;
  assign wen        = wen_c;
  assign ren        = ren_c;
  assign flush      = flush_q;
  assign frame_done = flush_q;
  assign cfg_err    = cfg_err_q;
  assign out_valid  = mem_valid_out && ((state_q == S_STREAM) || (state_q == S_DRAIN));
  assign busy       = (state_q != S_IDLE);
  assign col        = col_q;
  assign row        = row_q;
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_linebuf_seq_ctrl.sv
// Bench for linebuf_seq_ctrl: a cycle table for a small frame plus scoreboarded frames
// covering config errors, tiny frames, gapped input, mid-frame reset and ignored restarts.
module tb_linebuf_seq_ctrl;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] cfg_depth, cfg_img_width, cfg_img_height;
  logic             in_valid, in_ready, mem_valid_out;
  logic             wen, ren, flush, out_valid, busy, frame_done, cfg_err;
  logic [CNT_W-1:0] col, row, occupancy;

  linebuf_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_depth(cfg_depth), .cfg_img_width(cfg_img_width), .cfg_img_height(cfg_img_height),
    .in_valid(in_valid), .in_ready(in_ready), .mem_valid_out(mem_valid_out),
    .wen(wen), .ren(ren), .flush(flush), .out_valid(out_valid),
    .col(col), .row(row), .occupancy(occupancy),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tot_wen, tot_ren;

  typedef struct {
    logic st, iv, ir, wn, rn, fl, bz, ov;
    int   occ, col;
  } vec_t;
  vec_t tbl[15];

  logic [31:0] sb_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Inputs change 2 time units after the edge, outputs are sampled 1 unit later.
  task automatic drive(input logic s, input logic iv, input logic mv);
    @(posedge clk);
    #2;
    start = s; in_valid = iv; mem_valid_out = mv;
    #1;
    if (wen) tot_wen++;
    if (ren) tot_ren++;
  endtask

  task automatic setv(input int i, input logic st, input logic iv, input logic ir, input logic wn,
                      input logic rn, input logic fl, input logic bz, input logic ov,
                      input int oc, input int cl);
    tbl[i].st = st; tbl[i].iv = iv; tbl[i].ir = ir; tbl[i].wn = wn; tbl[i].rn = rn;
    tbl[i].fl = fl; tbl[i].bz = bz; tbl[i].ov = ov; tbl[i].occ = oc; tbl[i].col = cl;
  endtask

  task automatic run_frame(input int d, input int w, input int h, input bit toggle,
                           input bit inject);
    int   total, de, n_acc, n_dr, cyc, bound;
    bit   done, injected;
    logic iv, s;
    logic [31:0] exp_pos;
    total = w * h;
    de = (d < total) ? d : total;
    n_acc = 0; n_dr = 0; cyc = 0; done = 0; injected = 0;
    bound = 4 * total + 2 * d + 40;
    cfg_depth = CNT_W'(d); cfg_img_width = CNT_W'(w); cfg_img_height = CNT_W'(h);
    tot_wen = 0; tot_ren = 0;
    drive(1'b1, 1'b0, 1'b1);
    chk("start_in_ready", in_ready, 0);
    chk("start_busy", busy, 0);
    while (!done && cyc < bound) begin
      s = 1'b0;
      if (n_acc < total) iv = !(toggle && n_acc >= d && (cyc % 2 == 1));
      else iv = 1'b0;
      if (inject && !injected && n_acc == 6) begin
        s = 1'b1; cfg_depth = CNT_W'(9); injected = 1;
      end
      if (iv) sb_q.push_back({16'(n_acc / w), 16'(n_acc % w)});
      drive(s, iv, 1'b1);
      if (n_acc < total) begin
        chk("in_ready_input", in_ready, 1);
        chk("wen_input", wen, iv);
        chk("ren_input", ren, iv && (n_acc >= d));
        chk("occ_input", occupancy, (n_acc < d) ? n_acc : d);
        chk("out_valid_input", out_valid, n_acc >= d);
        if (iv) begin
          exp_pos = sb_q.pop_front();
          if (wen) chk("pos_rowcol", {row, col}, exp_pos);
          n_acc++;
        end
      end else if (n_dr < de) begin
        chk("drain_ren", ren, 1);
        chk("drain_wen", wen, 0);
        chk("drain_in_ready", in_ready, 0);
        chk("drain_occ", occupancy, de - n_dr);
        chk("drain_out_valid", out_valid, 1);
        chk("drain_flush", flush, 0);
        n_dr++;
      end else begin
        chk("done_flush", flush, 1);
        chk("done_frame_done", frame_done, 1);
        chk("done_ren", ren, 0);
        chk("done_busy", busy, 1);
        done = 1;
      end
      cyc++;
    end
    if (!done) chk("frame_timeout", 0, 1);
    drive(1'b0, 1'b0, 1'b1);
    chk("post_flush", flush, 0);
    chk("post_busy", busy, 0);
    chk("post_out_valid", out_valid, 0);
    chk("post_cfg_err", cfg_err, 0);
    chk("total_wen", tot_wen, total);
    chk("total_ren", tot_ren, total);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; mem_valid_out = 1'b1;
    cfg_depth = '0; cfg_img_width = '0; cfg_img_height = '0;
    tot_wen = 0; tot_ren = 0;

    //           st iv ir wn rn fl bz ov occ col
    setv( 0,     1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    setv( 1,     0, 1, 1, 1, 0, 0, 1, 0, 0, 0);
    setv( 2,     0, 1, 1, 1, 0, 0, 1, 0, 1, 1);
    setv( 3,     0, 1, 1, 1, 0, 0, 1, 0, 2, 2);
    setv( 4,     0, 1, 1, 1, 0, 0, 1, 0, 3, 3);
    setv( 5,     0, 1, 1, 1, 1, 0, 1, 1, 4, 0);
    setv( 6,     0, 1, 1, 1, 1, 0, 1, 1, 4, 1);
    setv( 7,     0, 1, 1, 1, 1, 0, 1, 1, 4, 2);
    setv( 8,     0, 1, 1, 1, 1, 0, 1, 1, 4, 3);
    setv( 9,     0, 1, 0, 0, 1, 0, 1, 1, 4, 0);
    setv(10,     0, 0, 0, 0, 1, 0, 1, 1, 3, 0);
    setv(11,     0, 0, 0, 0, 1, 0, 1, 1, 2, 0);
    setv(12,     0, 0, 0, 0, 1, 0, 1, 1, 1, 0);
    setv(13,     0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    setv(14,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wen", wen, 0);
    chk("rst_ren", ren, 0);
    chk("rst_flush", flush, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_rowcol", {row, col}, 0);
    chk("rst_out_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic frame: depth 4, 4x2, continuous input
    cfg_depth = 16'd4; cfg_img_width = 16'd4; cfg_img_height = 16'd2;
    tot_wen = 0; tot_ren = 0;
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].st, tbl[i].iv, 1'b1);
      chk($sformatf("t1c%0d_in_ready", i), in_ready, tbl[i].ir);
      chk($sformatf("t1c%0d_wen", i), wen, tbl[i].wn);
      chk($sformatf("t1c%0d_ren", i), ren, tbl[i].rn);
      chk($sformatf("t1c%0d_flush", i), flush, tbl[i].fl);
      chk($sformatf("t1c%0d_frame_done", i), frame_done, tbl[i].fl);
      chk($sformatf("t1c%0d_busy", i), busy, tbl[i].bz);
      chk($sformatf("t1c%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("t1c%0d_occ", i), occupancy, tbl[i].occ);
      chk($sformatf("t1c%0d_col", i), col, tbl[i].col);
    end
    chk("t1_total_wen", tot_wen, 8);
    chk("t1_total_ren", tot_ren, 8);

    // Illegal config: zero depth, then zero height
    cfg_depth = 16'd0; cfg_img_width = 16'd4; cfg_img_height = 16'd2;
    tot_wen = 0;
    drive(1'b1, 1'b1, 1'b0);
    chk("t2_err_same_cycle", cfg_err, 0);
    chk("t2_busy0", busy, 0);
    drive(1'b0, 1'b1, 1'b0);
    chk("t2_err_pulse", cfg_err, 1);
    chk("t2_busy1", busy, 0);
    chk("t2_in_ready", in_ready, 0);
    drive(1'b0, 1'b0, 1'b0);
    chk("t2_err_cleared", cfg_err, 0);
    cfg_depth = 16'd4; cfg_img_height = 16'd0;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    chk("t2_err_height", cfg_err, 1);
    chk("t2_busy_height", busy, 0);
    chk("t2_no_wen", tot_wen, 0);

    // Gapped input while streaming
    run_frame(4, 8, 2, 1'b1, 1'b0);

    // Depth larger than the whole frame
    run_frame(16, 3, 2, 1'b0, 1'b0);

    // Asynchronous reset in the middle of STREAM
    cfg_depth = 16'd4; cfg_img_width = 16'd4; cfg_img_height = 16'd2;
    drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    chk("t5_col_before", col, 2);
    chk("t5_row_before", row, 1);
    chk("t5_occ_before", occupancy, 4);
    in_valid = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("t5_in_ready", in_ready, 0);
    chk("t5_wen", wen, 0);
    chk("t5_ren", ren, 0);
    chk("t5_busy", busy, 0);
    chk("t5_occ", occupancy, 0);
    chk("t5_rowcol", {row, col}, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_flush", flush, 0);
    @(negedge clk);
    reset = 1'b0;
    run_frame(2, 2, 2, 1'b0, 1'b0);

    // Restart with a new depth while streaming must be ignored
    run_frame(4, 4, 3, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
